// File: rtl/softmax_exp_input_stream.sv
// Softmax input stage: streams LANES elements per beat and emits max - x per lane,
// registered, with a one-beat output buffer and a per-vector IDLE/RUN/DONE controller.

// Combinational add/subtract element. ARITH_TYPE 0 is IEEE-style binary floating point
// (DATA_WIDTH must equal 1+E+M): round-to-nearest-even, subnormals flushed to zero.
// Any other ARITH_TYPE is plain two's-complement integer arithmetic.
module softmax_addsub #(
  parameter int ARITH_TYPE = 0,
  parameter int DATA_WIDTH = 32,
  parameter int E          = 8,
  parameter int M          = 23
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  sub,
  output logic [DATA_WIDTH-1:0] y
);

  if (ARITH_TYPE != 0) begin : g_int
    assign y = sub ? (a - b) : (a + b);
  end else begin : g_fp
    // Working mantissa: hidden bit, fraction, then guard/round/sticky.
    localparam int FW = M + 4;
    localparam logic [E-1:0] EXP_MAX = '1;

    function automatic int lzc(input logic [FW-1:0] v);
      int n;
      n = FW;
      for (int i = 0; i < FW; i++) begin
        if (v[i]) n = FW - 1 - i;
      end
      return n;
    endfunction

    logic              sa, sb;
    logic [E-1:0]      ea, eb;
    logic [M-1:0]      fa, fb;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic              swap, eff_sub;
    logic              sl, ss;
    logic [E-1:0]      el, es, ediff;
    logic [M-1:0]      fl, fs;
    logic [FW-1:0]     ml, ms, ms_sh, shmask;
    logic [FW:0]       sum;
    logic [FW-1:0]     norm;
    int                lz;
    logic signed [E+1:0] exp_n;
    logic              round_up;
    logic [E+M-1:0]    mag;

    assign sa = a[E+M];
    assign ea = a[E+M-1:M];
    assign fa = a[M-1:0];
    assign sb = b[E+M] ^ sub;
    assign eb = b[E+M-1:M];
    assign fb = b[M-1:0];

    // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
    always_comb begin
      a_zero   = (ea == '0);
      b_zero   = (eb == '0);
      a_inf    = (ea == EXP_MAX) && (fa == '0);
      b_inf    = (eb == EXP_MAX) && (fb == '0);
      a_nan    = (ea == EXP_MAX) && (fa != '0);
      b_nan    = (eb == EXP_MAX) && (fb != '0);

      swap     = ({eb, fb} > {ea, fa});
      sl       = swap ? sb : sa;
      ss       = swap ? sa : sb;
      el       = swap ? eb : ea;
      es       = swap ? ea : eb;
      fl       = swap ? fb : fa;
      fs       = swap ? fa : fb;
      ediff    = el - es;
      eff_sub  = sl ^ ss;

      ml       = {1'b1, fl, 3'b000};
      ms       = {1'b1, fs, 3'b000};
      shmask   = '0;
      if (int'(ediff) >= FW) begin
        ms_sh  = {{(FW-1){1'b0}}, 1'b1};
      end else begin
        shmask = ~({FW{1'b1}} << ediff);
        ms_sh  = (ms >> ediff) | {{(FW-1){1'b0}}, |(ms & shmask)};
      end

      sum = eff_sub ? ({1'b0, ml} - {1'b0, ms_sh}) : ({1'b0, ml} + {1'b0, ms_sh});

      lz = 0;
      if (sum[FW]) begin
        norm  = sum[FW:1] | {{(FW-1){1'b0}}, sum[0]};
        exp_n = $signed({2'b00, el} + (E+2)'(1));
      end else begin
        lz    = lzc(sum[FW-1:0]);
        norm  = sum[FW-1:0] << lz;
        exp_n = $signed({2'b00, el} - (E+2)'(lz));
      end

      round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
      // A rounding carry out of the fraction ripples straight into the exponent field.
      mag      = {exp_n[E-1:0], norm[FW-2:3]} + (E+M)'(round_up);

      if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
        y = {1'b0, EXP_MAX, 1'b1, {(M-1){1'b0}}};
      end else if (a_inf) begin
        y = {sa, EXP_MAX, {M{1'b0}}};
      end else if (b_inf) begin
        y = {sb, EXP_MAX, {M{1'b0}}};
      end else if (a_zero && b_zero) begin
        y = {sa & sb, {(E+M){1'b0}}};
      end else if (a_zero) begin
        y = {sb, b[E+M-1:0]};
      end else if (b_zero) begin
        y = {sa, a[E+M-1:0]};
      end else if (!norm[FW-1]) begin
        y = '0;
      end else if (exp_n[E+1] || (exp_n == '0)) begin
        y = {sl, {(E+M){1'b0}}};
      end else if (exp_n[E:0] >= {1'b0, EXP_MAX}) begin
        y = {sl, EXP_MAX, {M{1'b0}}};
      end else begin
        y = {sl, mag};
      end
    end
  end

endmodule

module softmax_exp_input_stream #(
  parameter int ARITH_TYPE = 0,
  parameter int DATA_WIDTH = 32,
  parameter int E          = 8,
  parameter int M          = 23,
  parameter int LANES      = 4,
  parameter int NUM_IN     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        softmax_enable,
  input  logic [DATA_WIDTH-1:0]       max_input,
  input  logic [LANES*DATA_WIDTH-1:0] in_bus,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_bus,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        start_exp,
  output logic                        busy,
  output logic                        done
);

  localparam int BEATS = NUM_IN / LANES;
  localparam int CW    = $clog2(BEATS + 1);
  localparam logic [CW-1:0] BEATS_C  = CW'(BEATS);
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  if (LANES < 1 || (NUM_IN % LANES) != 0 || NUM_IN < LANES) begin : g_param_check
    $error("softmax_exp_input_stream: NUM_IN must be a positive multiple of LANES");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                      state_q, state_d;
  logic [DATA_WIDTH-1:0]       max_reg;
  logic [CW-1:0]               cnt;
  logic [LANES*DATA_WIDTH-1:0] diff_bus;
  logic                        in_fire, out_fire;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    softmax_addsub #(
      .ARITH_TYPE (ARITH_TYPE),
      .DATA_WIDTH (DATA_WIDTH),
      .E          (E),
      .M          (M)
    ) u_sub (
      .a   (max_reg),
      .b   (in_bus[k*DATA_WIDTH +: DATA_WIDTH]),
      .sub (1'b1),
      .y   (diff_bus[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = (state_q != IDLE);
    done     = 1'b0;
    case (state_q)
      IDLE: if (softmax_enable) state_d = RUN;
      RUN: begin
        // Accept only while beats remain and the single output slot is free or draining.
        in_ready = (cnt < BEATS_C) && (!out_valid || out_ready);
        if (out_fire && out_last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The output slot is cleared by reset along with the control state.
  always_ff @(posedge clk) begin
    if (reset) begin
      max_reg   <= '0;
      cnt       <= '0;
      out_bus   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      start_exp <= 1'b0;
    end else begin
      start_exp <= 1'b0;
      if (in_fire) begin
        out_bus   <= diff_bus;
        out_valid <= 1'b1;
        out_last  <= (cnt == LAST_CNT);
        start_exp <= (cnt == '0);
        cnt       <= cnt + CW'(1);
      end else if (out_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (state_q == IDLE && softmax_enable) begin
        max_reg <= max_input;
        cnt     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_softmax_exp_input_stream.sv
// Bench for softmax_exp_input_stream (float32, LANES=2, NUM_IN=4): directed vectors plus
// randomized vectors scored against an integer-valued reference of max - x.
module tb_softmax_exp_input_stream;

  localparam int LANES  = 2;
  localparam int NUM_IN = 4;
  localparam int BEATS  = NUM_IN / LANES;
  localparam int DW     = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              softmax_enable;
  logic [DW-1:0]     max_input;
  logic [LANES*DW-1:0] in_bus;
  logic              in_valid;
  logic              in_ready;
  logic [LANES*DW-1:0] out_bus;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              start_exp;
  logic              busy;
  logic              done;

  int total = 0;
  int bad   = 0;
  logic [63:0] obs[$];

  softmax_exp_input_stream #(
    .ARITH_TYPE (0),
    .DATA_WIDTH (DW),
    .E          (8),
    .M          (23),
    .LANES      (LANES),
    .NUM_IN     (NUM_IN)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .softmax_enable (softmax_enable),
    .max_input      (max_input),
    .in_bus         (in_bus),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_bus        (out_bus),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .start_exp      (start_exp),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Integer to float32 with round-to-nearest-even.
  function automatic logic [31:0] to_f32(input longint v);
    longint m, rem, half;
    int     p, sh;
    if (v == 0) return 32'h0;
    m = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 40; i++) if (m >= (longint'(1) << i)) p = i;
    if (p <= 23) begin
      m = m << (23 - p);
    end else begin
      sh   = p - 23;
      rem  = m & ((longint'(1) << sh) - 1);
      half = longint'(1) << (sh - 1);
      m    = m >> sh;
      if (rem > half || (rem == half && m[0])) m++;
      if (m == (longint'(1) << 24)) begin
        m = m >> 1;
        p++;
      end
    end
    return {(v < 0), 8'(127 + p), 23'(m & 64'h7FFFFF)};
  endfunction

  function automatic int rand_val(input bit big);
    if (big) return int'($urandom_range(0, 33554430)) - 16777215;
    return int'($urandom_range(0, 4000)) - 2000;
  endfunction

  // mode 0: free flow, 1: 3-cycle output stall after first result, 2: in_valid 1,0,1, 3: random.
  task automatic run_vector(input int mx, input int xs[NUM_IN], input int mode, input bit busy_start);
    int          acc, phase, cyc, stall;
    bit          seen, in_fire, out_fire, exp_ready, first, lst;
    logic [63:0] q_data[$];
    bit          q_last[$];
    acc = 0; phase = 0; cyc = 0; stall = 0; seen = 0;
    obs.delete();
    softmax_enable = 1'b1;
    max_input      = to_f32(longint'(mx));
    in_valid       = 1'b0;
    in_bus         = {$urandom, $urandom};
    out_ready      = 1'b1;
    #1;
    check("idle_in_ready", in_ready, 0);
    check("idle_busy", busy, 0);
    @(posedge clk); #1;
    phase = 1;
    while (phase != 0 && cyc < 200) begin
      case (mode)
        1: begin
          in_valid  = 1'b1;
          out_ready = !(seen && stall < 3);
          if (!out_ready) stall++;
        end
        2: begin
          in_valid  = (cyc % 2 == 0);
          out_ready = 1'b1;
        end
        3: begin
          in_valid  = ($urandom_range(0, 3) != 0);
          out_ready = ($urandom_range(0, 2) != 0);
        end
        default: begin
          in_valid  = 1'b1;
          out_ready = 1'b1;
        end
      endcase
      if (acc < BEATS)
        in_bus = {to_f32(longint'(xs[2*acc+1])), to_f32(longint'(xs[2*acc]))};
      else
        in_bus = {$urandom, $urandom};
      softmax_enable = busy_start;
      max_input      = busy_start ? 32'h41200000 : $urandom;
      #1;
      exp_ready = (phase == 1) && (acc < BEATS) && (q_data.size() == 0 || out_ready);
      check("in_ready", in_ready, exp_ready);
      check("busy", busy, 1);
      check("done", done, (phase == 2));
      in_fire  = in_valid && exp_ready;
      out_fire = (phase == 1) && (q_data.size() != 0) && out_ready;
      first    = (acc == 0);
      if (out_fire) obs.push_back(out_bus);
      @(posedge clk); #1;
      if (phase == 2) begin
        phase = 0;
      end else begin
        if (out_fire) begin
          void'(q_data.pop_front());
          lst = q_last.pop_front();
          if (lst) phase = 2;
        end
        if (in_fire) begin
          q_data.push_back({to_f32(longint'(mx) - longint'(xs[2*acc+1])),
                            to_f32(longint'(mx) - longint'(xs[2*acc]))});
          q_last.push_back(acc == BEATS - 1);
          acc++;
        end
      end
      check("start_exp", start_exp, (in_fire && first));
      check("out_valid", out_valid, (q_data.size() != 0));
      if (q_data.size() != 0) begin
        check("out_bus", out_bus, q_data[0]);
        check("out_last", out_last, q_last[0]);
        seen = 1;
      end
      cyc++;
    end
    softmax_enable = 1'b0;
    check("vector_completes", (phase == 0), 1);
    check("end_busy", busy, 0);
    check("end_done", done, 0);
    check("beats_out", obs.size(), BEATS);
  endtask

  task automatic reset_mid_vector();
    softmax_enable = 1'b1;
    max_input      = 32'h40400000;
    in_valid       = 1'b0;
    out_ready      = 1'b0;
    @(posedge clk); #1;
    softmax_enable = 1'b0;
    in_valid       = 1'b1;
    in_bus         = {32'h40000000, 32'h3F800000};
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mid_out_valid", out_valid, 1);
    check("mid_start_exp", start_exp, 1);
    check("mid_out_bus", out_bus, 64'h3F800000_40000000);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bus", out_bus, 0);
    check("rst_out_last", out_last, 0);
    check("rst_start_exp", start_exp, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_done", done, 0);
    reset     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("post_rst_done", done, 0);
      check("post_rst_out_valid", out_valid, 0);
      check("idle_ignores_input", in_ready, 0);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int basic[NUM_IN];
    int xs[NUM_IN];
    int mx;
    basic = '{1, 2, 3, 0};
    reset = 1'b1; softmax_enable = 1'b0; max_input = '0; in_bus = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_bus", out_bus, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_last", out_last, 0);
    check("reset_start_exp", start_exp, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_in_ready", in_ready, 0);
    reset = 1'b0;

    run_vector(3, basic, 0, 0);
    check("basic_beat0", obs[0], 64'h3F800000_40000000);
    check("basic_beat1", obs[1], 64'h40400000_00000000);

    run_vector(3, basic, 1, 0);
    check("bp_beat0", obs[0], 64'h3F800000_40000000);
    check("bp_beat1", obs[1], 64'h40400000_00000000);

    run_vector(3, basic, 2, 0);

    run_vector(3, basic, 0, 1);
    check("busy_start_beat0", obs[0], 64'h3F800000_40000000);
    check("busy_start_beat1", obs[1], 64'h40400000_00000000);

    reset_mid_vector();
    run_vector(3, basic, 0, 0);
    check("after_rst_beat0", obs[0], 64'h3F800000_40000000);

    for (int v = 0; v < 30; v++) begin
      bit big;
      big = ($urandom_range(0, 1) == 1);
      mx  = rand_val(big);
      for (int i = 0; i < NUM_IN; i++)
        xs[i] = ($urandom_range(0, 7) == 0) ? mx : rand_val(big);
      run_vector(mx, xs, (v % 4 == 0) ? 1 : 3, ($urandom_range(0, 1) == 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
